// File: rtl/skeeball_pkg.sv
// Shared definitions for the skee-ball sensor front end.
// Holds the qualifier FSM state encoding, default tick counts and count width,
// plus a helper that sizes a counter to hold a given terminal value.
package skeeball_pkg;

   typedef enum logic [2:0] {
      S_IDLE         = 3'd0,
      S_QUALIFY      = 3'd1,
      S_EVENT        = 3'd2,
      S_LOCKOUT      = 3'd3,
      S_WAIT_RELEASE = 3'd4
   } state_t;

   localparam int DEF_DEBOUNCE_TICKS = 3;
   localparam int DEF_LOCKOUT_TICKS  = 5;
   localparam int DEF_STUCK_TICKS    = 50;
   localparam int DEF_CNT_W          = 8;

   // Bits needed for a counter that must reach max_val (max_val >= 1).
   function automatic int cnt_bits(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/sense_sync2.sv
// Purpose: two-flop synchronizer for one asynchronous sensor line.
// Latency: 2 clk from d to q. Backpressure: none, free-running.
// Ports: clk, Reset (async, active-high, clears both flops), d (async in), q (synced out).
module sense_sync2 (
   input  logic clk,
   input  logic Reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/skeeball_sense_qualifier.sv
// Purpose: debounces one ball-hole sensor into a single-clk event_pulse and a saturating hit count.
// Latency: 2 clk sync, then event_pulse the clk after the DEBOUNCE_TICKS-th high tick.
// Backpressure: none; hits during lockout or while the sensor stays held are ignored.
// Ports: clk, Reset (async, active-high), tick (divider enable), sensor_raw (async sensor),
//        clear (sync clear of event_count and fault), event_pulse, event_count, busy, fault.
// Optional: define SENSE_STUCK_DETECT_EN to enable the sticky stuck-sensor fault; otherwise fault is 0.
module skeeball_sense_qualifier
   import skeeball_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
   parameter int LOCKOUT_TICKS  = DEF_LOCKOUT_TICKS,
   parameter int CNT_W          = DEF_CNT_W,
   parameter int STUCK_TICKS    = DEF_STUCK_TICKS
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             tick,
   input  logic             sensor_raw,
   input  logic             clear,
   output logic             event_pulse,
   output logic [CNT_W-1:0] event_count,
   output logic             busy,
   output logic             fault
);

   localparam int DW = cnt_bits(DEBOUNCE_TICKS);
   localparam int LW = cnt_bits(LOCKOUT_TICKS);
   localparam logic [DW-1:0]    DEB_LAST  = DW'(DEBOUNCE_TICKS - 1);
   localparam logic [LW-1:0]    LOCK_LAST = LW'(LOCKOUT_TICKS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   state_t          state;
   logic [DW-1:0]   dcnt;
   logic [LW-1:0]   lcnt;
   logic            s_sync;
   logic            qual_done;
   logic            lock_done;

   sense_sync2 u_sync (
      .clk   (clk),
      .Reset (Reset),
      .d     (sensor_raw),
      .q     (s_sync)
   );

   // Terminal ticks: the transition fires on the tick itself so the pulse
   // lands exactly one clk after the last qualifying tick.
   assign qual_done = (state == S_QUALIFY) && s_sync && tick && (dcnt == DEB_LAST);
   assign lock_done = (state == S_LOCKOUT) && tick && (lcnt == LOCK_LAST);

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state       <= S_IDLE;
         dcnt        <= '0;
         lcnt        <= '0;
         event_pulse <= 1'b0;
         busy        <= 1'b0;
      end else begin
         event_pulse <= 1'b0;
         case (state)
            S_IDLE: begin
               if (s_sync) begin
                  state <= S_QUALIFY;
                  dcnt  <= '0;
                  busy  <= 1'b1;
               end
            end
            S_QUALIFY: begin
               // A low sample rejects the bounce even on a tick clk.
               if (!s_sync) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else if (tick) begin
                  dcnt <= dcnt + 1'b1;
                  if (qual_done) begin
                     if (fault) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                     end else begin
                        state       <= S_EVENT;
                        event_pulse <= 1'b1;
                     end
                  end
               end
            end
            S_EVENT: begin
               state <= S_LOCKOUT;
               lcnt  <= '0;
            end
            S_LOCKOUT: begin
               if (tick) begin
                  lcnt <= lcnt + 1'b1;
                  if (lock_done) state <= S_WAIT_RELEASE;
               end
            end
            S_WAIT_RELEASE: begin
               if (!s_sync) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Clear takes effect before the hit, so clear during EVENT leaves 1.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         event_count <= '0;
      end else if (state == S_EVENT) begin
         if (clear)                     event_count <= {{(CNT_W-1){1'b0}}, 1'b1};
         else if (event_count != CNT_MAX) event_count <= event_count + 1'b1;
      end else if (clear) begin
         event_count <= '0;
      end
   end

`ifdef SENSE_STUCK_DETECT_EN
   localparam int SW = cnt_bits(STUCK_TICKS);
   localparam logic [SW-1:0] STUCK_END  = SW'(STUCK_TICKS);
   localparam logic [SW-1:0] STUCK_LAST = SW'(STUCK_TICKS - 1);

   logic [SW-1:0] scnt;
   logic          stuck_inc;

   // scnt saturates at STUCK_TICKS so a long hold cannot wrap and re-arm.
   assign stuck_inc = (state == S_WAIT_RELEASE) && s_sync && tick && (scnt != STUCK_END);

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         scnt  <= '0;
         fault <= 1'b0;
      end else begin
         if (lock_done)      scnt <= '0;
         else if (stuck_inc) scnt <= scnt + 1'b1;
         fault <= clear ? 1'b0 : (fault | (stuck_inc && (scnt == STUCK_LAST)));
      end
   end
`else
   assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_skeeball_sense_qualifier.sv
// Bench for skeeball_sense_qualifier: vector table, directed corner sequences and
// random traffic checked every clk against a behavioural model of the hit rules.
module tb_skeeball_sense_qualifier;

   localparam int D    = 3;
   localparam int L    = 5;
   localparam int MAXC = 255;
`ifdef SENSE_STUCK_DETECT_EN
   localparam int TB_STUCK = 4;
   localparam bit STUCK_ON = 1'b1;
`else
   localparam int TB_STUCK = 50;
   localparam bit STUCK_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       Reset = 1'b1;
   logic       tick = 1'b0;
   logic       sensor_raw = 1'b0;
   logic       clear = 1'b0;
   logic       event_pulse;
   logic [7:0] event_count;
   logic       busy;
   logic       fault;

   int n_checks = 0;
   int n_err    = 0;
   int pulse_seen = 0;
   int tphase = 0;
   bit tick_rand = 1'b0;

   skeeball_sense_qualifier #(
      .DEBOUNCE_TICKS (D),
      .LOCKOUT_TICKS  (L),
      .CNT_W          (8),
      .STUCK_TICKS    (TB_STUCK)
   ) dut (
      .clk         (clk),
      .Reset       (Reset),
      .tick        (tick),
      .sensor_raw  (sensor_raw),
      .clear       (clear),
      .event_pulse (event_pulse),
      .event_count (event_count),
      .busy        (busy),
      .fault       (fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Sensor seen through a 2-clk delay line; a hit is D high ticks in a row,
   // followed by L ticks of deafness and then a wait for the sensor to drop.
   bit m_d1 = 0, m_d2 = 0;
   bit m_qual = 0, m_hit = 0, m_hold = 0, m_fault = 0;
   int m_q = 0, m_lock_left = 0, m_st = 0, m_count = 0;

   always @(posedge clk or posedge Reset) begin
      if (Reset) begin
         m_d1 = 0; m_d2 = 0; m_qual = 0; m_hit = 0; m_hold = 0; m_fault = 0;
         m_q = 0; m_lock_left = 0; m_st = 0; m_count = 0;
      end else begin
         bit s, old_fault;
         s = m_d2; m_d2 = m_d1; m_d1 = sensor_raw;
         old_fault = m_fault;
         if (m_hit) begin
            m_count = (clear ? 0 : m_count) + 1;
            if (m_count > MAXC) m_count = MAXC;
            m_hit = 0;
            m_lock_left = L;
         end else begin
            if (clear) m_count = 0;
            if (m_lock_left > 0) begin
               if (tick) begin
                  m_lock_left--;
                  if (m_lock_left == 0) begin m_hold = 1; m_st = 0; end
               end
            end else if (m_hold) begin
               if (!s) m_hold = 0;
               else if (STUCK_ON && tick) begin
                  m_st++;
                  if (m_st == TB_STUCK) m_fault = 1;
               end
            end else if (m_qual) begin
               if (!s) m_qual = 0;
               else if (tick) begin
                  m_q++;
                  if (m_q == D) begin m_qual = 0; m_hit = !old_fault; end
               end
            end else if (s) begin
               m_qual = 1; m_q = 0;
            end
         end
         if (clear) m_fault = 0;
      end
   end

   // Continuous comparison against the model, away from the active edge.
   bit prev_pulse = 0;
   always @(negedge clk) begin
      chk("mon_pulse", event_pulse, m_hit);
      chk("mon_count", event_count, m_count);
      chk("mon_busy",  busy, m_qual | m_hit | (m_lock_left > 0) | m_hold);
      chk("mon_fault", fault, m_fault);
      if (event_pulse && prev_pulse) chk("pulse_width", 2, 1);
      if (event_pulse) pulse_seen++;
      prev_pulse = event_pulse;
   end

   // One clk of stimulus; tick is every 4th clk unless randomised.
   task automatic drive(input bit raw, input bit clr);
      sensor_raw = raw;
      clear      = clr;
      tick       = tick_rand ? ($urandom_range(0, 3) == 0) : (tphase == 3);
      tphase     = (tphase + 1) % 4;
      @(posedge clk);
      #1;
      clear = 1'b0;
   endtask

   task automatic drive_n(input bit raw, input int n);
      for (int i = 0; i < n; i++) drive(raw, 1'b0);
   endtask

   typedef struct {
      int hi; int lo; int reps; bit clr;
      int exp_pulses; int exp_count; bit exp_fault;
   } vec_t;

   vec_t tbl[5];

   initial begin
      tbl[0] = '{hi: 20,  lo: 40, reps: 1, clr: 0, exp_pulses: 1, exp_count: 1, exp_fault: 0};
      tbl[1] = '{hi: 6,   lo: 1,  reps: 3, clr: 0, exp_pulses: 0, exp_count: 1, exp_fault: 0};
      tbl[2] = '{hi: 200, lo: 1,  reps: 1, clr: 0, exp_pulses: 1, exp_count: 2, exp_fault: STUCK_ON};
      tbl[3] = '{hi: 0,   lo: 0,  reps: 0, clr: 1, exp_pulses: 0, exp_count: 0, exp_fault: 0};
      tbl[4] = '{hi: 20,  lo: 40, reps: 2, clr: 0, exp_pulses: 2, exp_count: 2, exp_fault: 0};

      // ---- reset state, then reset mid-lockout ----
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pulse", event_pulse, 0);
      chk("rst_count", event_count, 0);
      chk("rst_busy",  busy, 0);
      chk("rst_fault", fault, 0);
      Reset = 1'b0;
      begin
         int k;
         k = 0;
         while (!event_pulse && k < 40) begin drive(1'b1, 1'b0); k++; end
         chk("pre_rst_pulse_seen", event_pulse, 1);
      end
      drive_n(1'b1, 3);
      chk("lockout_busy", busy, 1);
      #2 Reset = 1'b1;
      #2;
      chk("async_rst_busy",  busy, 0);
      chk("async_rst_count", event_count, 0);
      Reset = 1'b0;
      drive(1'b0, 1'b0);
      chk("post_rst_busy",  busy, 0);
      chk("post_rst_count", event_count, 0);
      chk("post_rst_pulse", event_pulse, 0);
      chk("post_rst_fault", fault, 0);
      drive_n(1'b0, 4);

      // ---- vector table ----
      for (int r = 0; r < 5; r++) begin
         pulse_seen = 0;
         for (int k = 0; k < tbl[r].reps; k++) begin
            drive_n(1'b1, tbl[r].hi);
            drive_n(1'b0, tbl[r].lo);
         end
         drive_n(1'b0, 40);
         if (tbl[r].clr) drive(1'b0, 1'b1);
         drive_n(1'b0, 2);
         chk($sformatf("row%0d_pulses", r), pulse_seen, tbl[r].exp_pulses);
         chk($sformatf("row%0d_count",  r), event_count, tbl[r].exp_count);
         chk($sformatf("row%0d_fault",  r), fault, tbl[r].exp_fault);
         chk($sformatf("row%0d_busy",   r), busy, 0);
         if (tbl[r].exp_fault) begin drive(1'b0, 1'b1); drive_n(1'b0, 2); end
      end

      // ---- saturation ----
      drive(1'b0, 1'b1);
      drive_n(1'b0, 2);
      pulse_seen = 0;
      for (int h = 0; h < 257; h++) begin
         drive_n(1'b1, 16);
         drive_n(1'b0, 24);
      end
      chk("sat_pulses", pulse_seen, 257);
      chk("sat_count",  event_count, 255);

      // ---- clear coincident with the EVENT clk ----
      begin
         int k;
         k = 0;
         while (!event_pulse && k < 40) begin drive(1'b1, 1'b0); k++; end
         chk("clr_evt_pulse_seen", event_pulse, 1);
         drive(1'b1, 1'b1);
         chk("clr_evt_count", event_count, 1);
      end
      drive_n(1'b0, 40);

`ifdef SENSE_STUCK_DETECT_EN
      // ---- stuck sensor ----
      pulse_seen = 0;
      drive_n(1'b1, 200);
      chk("stuck_fault_set", fault, 1);
      chk("stuck_one_pulse", pulse_seen, 1);
      drive_n(1'b0, 40);
      pulse_seen = 0;
      drive_n(1'b1, 20);
      drive_n(1'b0, 40);
      chk("stuck_blocked_pulses", pulse_seen, 0);
      chk("stuck_blocked_count",  event_count, 2);
      drive(1'b0, 1'b1);
      chk("stuck_cleared_fault", fault, 0);
      chk("stuck_cleared_count", event_count, 0);
      drive_n(1'b1, 20);
      drive_n(1'b0, 40);
      chk("stuck_after_clear_count", event_count, 1);
`endif

      // ---- random traffic, random tick ----
      tick_rand = 1'b1;
      begin
         int cyc;
         bit lvl;
         cyc = 0;
         lvl = 1'b0;
         while (cyc < 4000) begin
            int len;
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) drive(lvl, $urandom_range(0, 59) == 0);
            cyc += len;
            lvl = ~lvl;
         end
      end
      tick_rand = 1'b0;
      drive_n(1'b0, 4);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
